// File: rtl/plb_bram_responder_pkg.sv
// Shared constants and FSM encoding for the PLB BRAM responder and the RSA core's PLB side.
package plb_bram_responder_pkg;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;
endpackage

// File: rtl/plb_bram_responder_if.sv
// PLB initiator port plus host word port of the BRAM responder.
interface plb_bram_responder_if;
  import plb_bram_responder_pkg::*;

  logic          PLB_en;
  logic          PLB_we;
  logic [AW-1:0] PLB_addr;
  logic [DW-1:0] PLB_dout;
  logic [DW-1:0] PLB_din;

  logic          host_val;
  logic          host_rdy;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  modport master (
    output PLB_en, PLB_we, PLB_addr, PLB_dout,
    input  PLB_din,
    output host_val, host_we, host_addr, host_wdata,
    input  host_rdy, host_rdata, host_rvalid
  );

  modport slave (
    input  PLB_en, PLB_we, PLB_addr, PLB_dout,
    output PLB_din,
    input  host_val, host_we, host_addr, host_wdata,
    output host_rdy, host_rdata, host_rvalid
  );
endinterface

// File: rtl/plb_bram_responder_tdp_ram.sv
// True dual-port read-first RAM; outputs registered and held between reads, array not reset.
module plb_bram_responder_tdp_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic          a_re,
  input  logic          a_zero,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic          b_we,
  input  logic          b_re,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout
);
  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    if (b_we) mem[b_addr] <= b_din;
  end

  // a_zero forces a read to return 0 without touching the array (port A busy clearing)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (a_re) a_dout <= a_zero ? '0 : mem[a_addr];
      if (b_re) b_dout <= mem[b_addr];
    end
  end
endmodule

// File: rtl/plb_bram_responder.sv
// PLB BRAM responder: clear sequencer, PLB port on RAM port A, handshaked host port on port B.
module plb_bram_responder
  import plb_bram_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 sys_rst,
  plb_bram_responder_if.slave  bus,
  input  logic                 clr_req,
  output logic                 init_done
);
  localparam int STAGES = 1;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clearing, collision, host_acc;
  logic          a_we, a_re;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic          b_we, b_re;
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign clearing  = (state_q == CLEAR);
  assign init_done = (state_q == IDLE);

  // PLB write wins a same-address double write; host keeps its request up and retries
  assign collision = bus.PLB_en & bus.PLB_we & bus.host_val & bus.host_we &
                     (bus.host_addr == bus.PLB_addr);
  assign bus.host_rdy = init_done & ~collision;
  assign host_acc     = bus.host_val & bus.host_rdy;

  assign a_we   = clearing | (bus.PLB_en & bus.PLB_we);
  assign a_re   = bus.PLB_en & ~bus.PLB_we;
  assign a_addr = clearing ? clr_cnt_q : bus.PLB_addr;
  assign a_din  = clearing ? '0 : bus.PLB_dout;
  assign b_we   = host_acc & bus.host_we;
  assign b_re   = host_acc & ~bus.host_we;

  plb_bram_responder_tdp_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk    (clk),
    .rst_n  (sys_rst),
    .a_we   (a_we),
    .a_re   (a_re),
    .a_zero (clearing),
    .a_addr (a_addr),
    .a_din  (a_din),
    .a_dout (bus.PLB_din),
    .b_we   (b_we),
    .b_re   (b_re),
    .b_addr (bus.host_addr),
    .b_din  (bus.host_wdata),
    .b_dout (bus.host_rdata)
  );

  assign vld_pipe[0] = b_re;
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) vld_pipe[STAGES:1] <= '0;
    else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end
  assign bus.host_rvalid = vld_pipe[STAGES];
endmodule

// File: tb/tb_plb_bram_responder.sv
// Directed bench for plb_bram_responder: clear timing, both ports, collisions, clear and reset-mid-clear.
module tb_plb_bram_responder;
  import plb_bram_responder_pkg::*;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  logic clr_req = 1'b0;
  logic init_done;
  int   checks = 0;
  int   errors = 0;

  plb_bram_responder_if bus ();

  plb_bram_responder dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .bus       (bus.slave),
    .clr_req   (clr_req),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.PLB_en = 0; bus.PLB_we = 0; bus.PLB_addr = '0; bus.PLB_dout = '0;
    bus.host_val = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bus.host_val = 1; bus.host_we = 1; bus.host_addr = a; bus.host_wdata = d;
    while (!bus.host_rdy && n < 20) begin tick(); n++; end
    checks++;
    if (bus.host_rdy !== 1'b1) begin
      errors++; $display("FAIL host_write_rdy addr=%0h got rdy=%b want 1", a, bus.host_rdy);
    end
    tick();
    bus.host_val = 0; bus.host_we = 0;
  endtask

  task automatic plb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.PLB_en = 1; bus.PLB_we = 1; bus.PLB_addr = a; bus.PLB_dout = d;
    tick();
    bus.PLB_en = 0; bus.PLB_we = 0;
  endtask

  task automatic plb_read_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.PLB_en = 1; bus.PLB_we = 0; bus.PLB_addr = a;
    tick();
    bus.PLB_en = 0;
    checks++;
    if (bus.PLB_din !== exp) begin
      errors++; $display("FAIL %s addr=%0h got %h want %h", nm, a, bus.PLB_din, exp);
    end
  endtask

  task automatic host_read_chk(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.host_val = 1; bus.host_we = 0; bus.host_addr = a;
    tick();
    bus.host_val = 0;
    checks++;
    if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== exp) begin
      errors++;
      $display("FAIL %s addr=%0h got rvalid=%b rdata=%h want 1 %h", nm, a, bus.host_rvalid, bus.host_rdata, exp);
    end
    tick();
    checks++;
    if (bus.host_rvalid !== 1'b0) begin
      errors++; $display("FAIL %s_pulse got rvalid=%b want 0", nm, bus.host_rvalid);
    end
  endtask

  // counts edges until init_done is seen high, starting right after the event that began CLEAR
  task automatic wait_init(input string nm);
    int n = 0;
    while (!init_done && n < 3000) begin tick(); n++; end
    checks++;
    if (n != DEPTH || init_done !== 1'b1) begin
      errors++; $display("FAIL %s cycles got %0d want %0d", nm, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    sys_rst = 0;
    repeat (3) tick();
    checks++;
    if (bus.PLB_din !== '0 || bus.host_rdata !== '0 || bus.host_rvalid !== 1'b0 ||
        bus.host_rdy !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got din=%h rdata=%h rvalid=%b rdy=%b done=%b want all 0",
               bus.PLB_din, bus.host_rdata, bus.host_rvalid, bus.host_rdy, init_done);
    end
    sys_rst = 1;
    wait_init("reset_init_done");
    plb_read_chk("zero_0", 10'd0, 32'h0);
    plb_read_chk("zero_511", 10'd511, 32'h0);
    plb_read_chk("zero_1023", 10'd1023, 32'h0);
  endtask

  task automatic test_host_wr_plb_rd();
    host_write(10'h03A, 32'h12345678);
    plb_read_chk("plb_rd_3a", 10'h03A, 32'h12345678);
    repeat (3) tick();
    plb_write(10'h100, 32'h0BADF00D);
    checks++;
    if (bus.PLB_din !== 32'h12345678) begin
      errors++; $display("FAIL plb_din_hold got %h want 12345678", bus.PLB_din);
    end
    plb_read_chk("plb_rd_100", 10'h100, 32'h0BADF00D);
  endtask

  task automatic test_plb_wr_host_rd();
    plb_write(10'h3FF, 32'hDEADBEEF);
    host_read_chk("host_rd_3ff", 10'h3FF, 32'hDEADBEEF);
    repeat (2) tick();
    checks++;
    if (bus.host_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL host_rdata_hold got %h want deadbeef", bus.host_rdata);
    end
  endtask

  task automatic test_collision();
    bus.PLB_en = 1; bus.PLB_we = 1; bus.PLB_addr = 10'h010; bus.PLB_dout = 32'hAAAA0000;
    bus.host_val = 1; bus.host_we = 1; bus.host_addr = 10'h010; bus.host_wdata = 32'h5555FFFF;
    #1;
    checks++;
    if (bus.host_rdy !== 1'b0) begin
      errors++; $display("FAIL collision_rdy got %b want 0", bus.host_rdy);
    end
    tick();
    bus.PLB_en = 0; bus.PLB_we = 0;
    #1;
    checks++;
    if (bus.host_rdy !== 1'b1) begin
      errors++; $display("FAIL retry_rdy got %b want 1", bus.host_rdy);
    end
    tick();
    bus.host_val = 0; bus.host_we = 0;
    plb_read_chk("collision_final", 10'h010, 32'h5555FFFF);
    // host read and PLB write to the same word in one cycle: host sees the old word
    bus.PLB_en = 1; bus.PLB_we = 1; bus.PLB_addr = 10'h010; bus.PLB_dout = 32'h00000001;
    host_read_chk("read_first", 10'h010, 32'h5555FFFF);
    bus.PLB_en = 0; bus.PLB_we = 0;
    plb_read_chk("after_read_first", 10'h010, 32'h00000001);
  endtask

  task automatic test_clear_req();
    int n = 0;
    int rdy_seen = 0;
    plb_write(10'h005, 32'h11111111);
    // host read accepted on the final IDLE cycle still returns data
    clr_req = 1;
    bus.host_val = 1; bus.host_we = 0; bus.host_addr = 10'h03A;
    tick();
    clr_req = 0;
    checks++;
    if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== 32'h12345678 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL last_idle_read got rvalid=%b rdata=%h done=%b want 1 12345678 0",
               bus.host_rvalid, bus.host_rdata, init_done);
    end
    while (!init_done && n < 3000) begin
      if (bus.host_rdy !== 1'b0) rdy_seen++;
      if (n == 50) begin bus.PLB_en = 1; bus.PLB_we = 0; bus.PLB_addr = 10'h3FF; end
      if (n == 51) begin
        bus.PLB_en = 0;
        checks++;
        if (bus.PLB_din !== 32'h0) begin
          errors++; $display("FAIL clear_plb_read got %h want 0", bus.PLB_din);
        end
      end
      if (n == 100) begin bus.PLB_en = 1; bus.PLB_we = 1; bus.PLB_addr = 10'h005; bus.PLB_dout = 32'h7; end
      if (n == 101) begin bus.PLB_en = 0; bus.PLB_we = 0; end
      tick();
      n++;
    end
    bus.host_val = 0;
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL clear_req_cycles got %0d want %0d", n, DEPTH);
    end
    checks++;
    if (rdy_seen != 0) begin
      errors++; $display("FAIL clear_host_rdy got %0d rdy cycles want 0", rdy_seen);
    end
    plb_read_chk("dropped_wr_5", 10'h005, 32'h0);
    plb_read_chk("cleared_3a", 10'h03A, 32'h0);
  endtask

  task automatic test_reset_mid_clear();
    host_write(10'd900, 32'hCAFEF00D);
    plb_write(10'd100, 32'h0BADCAFE);
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (300) tick();
    sys_rst = 0;
    tick();
    sys_rst = 1;
    wait_init("reset_mid_clear_init_done");
    plb_read_chk("mid_clear_900", 10'd900, 32'h0);
    plb_read_chk("mid_clear_100", 10'd100, 32'h0);
    host_read_chk("mid_clear_host_1023", 10'd1023, 32'h0);
  endtask

  initial begin
    test_reset();
    test_host_wr_plb_rd();
    test_plb_wr_host_rd();
    test_collision();
    test_clear_req();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
